// File: rtl/call_ret_seq_if.sv
// Call/return sequencer bus: request side, stack-pointer link and stack RAM port.
// err_clr exists only when CRS_STICKY_ERR_EN is defined.
interface call_ret_seq_if #(
   parameter int AW = 8,
   parameter int DW = 8
);
   logic          call_req;
   logic          ret_req;
   logic [DW-1:0] pc_in;
   logic          sp_en;
   logic          sp_rw;
   logic [AW-1:0] sp_addr;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic          mem_re;
   logic [DW-1:0] mem_rdata;
   logic [DW-1:0] ret_pc;
   logic          ret_valid;
   logic          busy;
   logic          done;
   logic          err_ovf;
   logic          err_unf;
   logic [6:0]    depth;
`ifdef CRS_STICKY_ERR_EN
   logic          err_clr;
`endif

   modport slave (
      input  call_req, ret_req, pc_in, sp_addr, mem_rdata,
`ifdef CRS_STICKY_ERR_EN
      input  err_clr,
`endif
      output sp_en, sp_rw, mem_addr, mem_we, mem_wdata, mem_re,
      output ret_pc, ret_valid, busy, done, err_ovf, err_unf, depth
   );

   modport master (
      output call_req, ret_req, pc_in, sp_addr, mem_rdata,
`ifdef CRS_STICKY_ERR_EN
      output err_clr,
`endif
      input  sp_en, sp_rw, mem_addr, mem_we, mem_wdata, mem_re,
      input  ret_pc, ret_valid, busy, done, err_ovf, err_unf, depth
   );
endinterface

// File: rtl/call_ret_seq.sv
// Call/return sequencer: pushes return PCs to stack RAM on CALL, pops on RET.
// Optional CRS_STICKY_ERR_EN: sticky err_ovf/err_unf cleared by err_clr.
module call_ret_seq #(
   parameter int AW    = 8,
   parameter int DW    = 8,
   parameter int DEPTH = 80
) (
   input logic           clk,
   input logic           rst,
   call_ret_seq_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE, PUSH_REQ, PUSH_WR, POP_REQ, POP_RD, POP_CAP, FIN
   } state_e;

   localparam logic [6:0] DMAX = 7'(DEPTH);

   state_e        state_q, state_d;
   logic [DW-1:0] pc_q, pc_d;
   logic [6:0]    depth_q, depth_d;
   logic [DW-1:0] ret_pc_q;
   logic          sp_en_q, sp_rw_q, mem_we_q, mem_re_q;
   logic          ret_valid_q, done_q;
   logic          err_ovf_q, err_ovf_d;
   logic          err_unf_q, err_unf_d;
   logic          ovf_set, unf_set;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      depth_d = depth_q;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      unique case (state_q)
         IDLE: begin
            // CALL has priority; a simultaneous RET is dropped
            if (bus.call_req) begin
               if (depth_q == DMAX) begin
                  ovf_set = 1'b1;
                  state_d = FIN;
               end else begin
                  pc_d    = bus.pc_in;
                  state_d = PUSH_REQ;
               end
            end else if (bus.ret_req) begin
               if (depth_q == 7'd0) begin
                  unf_set = 1'b1;
                  state_d = FIN;
               end else begin
                  state_d = POP_REQ;
               end
            end
         end
         PUSH_REQ: state_d = PUSH_WR;
         PUSH_WR: begin
            depth_d = depth_q + 7'd1;
            state_d = FIN;
         end
         POP_REQ: state_d = POP_RD;
         POP_RD: begin
            depth_d = depth_q - 7'd1;
            state_d = POP_CAP;
         end
         POP_CAP: state_d = FIN;
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
`ifdef CRS_STICKY_ERR_EN
      err_ovf_d = bus.err_clr ? 1'b0 : (err_ovf_q | ovf_set);
      err_unf_d = bus.err_clr ? 1'b0 : (err_unf_q | unf_set);
`else
      err_ovf_d = ovf_set;
      err_unf_d = unf_set;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         pc_q        <= '0;
         depth_q     <= '0;
         ret_pc_q    <= '0;
         sp_en_q     <= 1'b0;
         sp_rw_q     <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
         ret_valid_q <= 1'b0;
         done_q      <= 1'b0;
         err_ovf_q   <= 1'b0;
         err_unf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         depth_q     <= depth_d;
         sp_en_q     <= (state_d == PUSH_REQ) || (state_d == POP_REQ);
         sp_rw_q     <= (state_d == POP_REQ);
         mem_we_q    <= (state_d == PUSH_WR);
         mem_re_q    <= (state_d == POP_RD);
         // RAM data arrives in POP_CAP; ret_pc and ret_valid show it in FIN
         ret_valid_q <= (state_q == POP_CAP);
         if (state_q == POP_CAP) ret_pc_q <= bus.mem_rdata;
         done_q      <= (state_d == FIN);
         err_ovf_q   <= err_ovf_d;
         err_unf_q   <= err_unf_d;
      end
   end

   // sp_addr is only valid in the cycle after sp_en, so it is passed through
   assign bus.mem_addr  = (state_q == PUSH_WR || state_q == POP_RD)
                        ? bus.sp_addr : '0;
   assign bus.mem_wdata = mem_we_q ? pc_q : '0;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_re    = mem_re_q;
   assign bus.sp_en     = sp_en_q;
   assign bus.sp_rw     = sp_rw_q;
   assign bus.ret_pc    = ret_pc_q;
   assign bus.ret_valid = ret_valid_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = done_q;
   assign bus.err_ovf   = err_ovf_q;
   assign bus.err_unf   = err_unf_q;
   assign bus.depth     = depth_q;
endmodule
